// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one byte transmitter between N byte-stream requesters.
//                Round-robin arbitration with packet lock (owner keeps the link
//                until its byte flagged last) and an optional lock timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N            = 2,
    parameter int IDW          = 1,
    parameter int LOCK_TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid_i,
    input  logic [8*N-1:0]   req_data_i,
    input  logic [N-1:0]     req_last_i,
    output logic [N-1:0]     req_ready_o,
    input  logic             output_busy_i,
    output logic             output_en_o,
    output logic [7:0]       output_data_o,
    output logic [IDW-1:0]   grant_id_o,
    output logic             locked_o
);

    localparam int              CNTW    = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [IDW-1:0]  LAST_ID = IDW'(N - 1);
    localparam logic [CNTW-1:0] TMO_MAX = CNTW'(LOCK_TIMEOUT);
    localparam logic [IDW:0]    N_EXT   = (IDW + 1)'(N);

    // SETTLE exists because the transmitter raises busy one cycle late.
    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t          state_q;
    logic [IDW-1:0]  rr_q;
    logic [CNTW-1:0] tmo_q;
    logic [IDW-1:0]  grant_id_q;
    logic            locked_q;
    logic            out_en_q;
    logic [7:0]      out_data_q;
    logic [N-1:0]    ready_q;

    logic [7:0]      slice_data [N];
    logic [IDW-1:0]  cand_id;
    logic            cand_vld;
    logic [IDW:0]    scan_sum;
    logic [IDW-1:0]  scan_id;
    logic [IDW-1:0]  rr_cand_d;
    logic [IDW-1:0]  rr_own_d;
    logic            tmo_fire;

    // Unpack the flat data bus into one byte per requester.
    for (genvar g = 0; g < N; g++) begin : g_slice
        assign slice_data[g] = req_data_i[8*g +: 8];
    end

    // Pick the eligible requester: the lock owner only, or else the first
    // valid requester at or above the round-robin pointer (wrapping at N).
    always_comb begin
        cand_vld = 1'b0;
        cand_id  = grant_id_q;
        scan_sum = '0;
        scan_id  = '0;
        if (locked_q) begin
            cand_vld = req_valid_i[grant_id_q];
        end else begin
            // Scan downward so the lowest offset from the pointer wins last.
            for (int k = N - 1; k >= 0; k--) begin
                scan_sum = {1'b0, rr_q} + (IDW + 1)'(k);
                if (scan_sum >= N_EXT) begin
                    scan_sum = scan_sum - N_EXT;
                end
                scan_id = scan_sum[IDW-1:0];
                if (req_valid_i[scan_id]) begin
                    cand_vld = 1'b1;
                    cand_id  = scan_id;
                end
            end
        end
    end

    // Pointer successors: after the granted index and after the lock owner.
    always_comb begin
        rr_cand_d = (cand_id == LAST_ID) ? '0 : cand_id + IDW'(1);
        rr_own_d  = (grant_id_q == LAST_ID) ? '0 : grant_id_q + IDW'(1);
    end

    assign tmo_fire = (LOCK_TIMEOUT != 0) && locked_q && (tmo_q == TMO_MAX);

    // Arbitration FSM with registered handshake outputs and lock timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ARB;
            rr_q       <= '0;
            tmo_q      <= '0;
            grant_id_q <= '0;
            locked_q   <= 1'b0;
            out_en_q   <= 1'b0;
            out_data_q <= '0;
            ready_q    <= '0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (!output_busy_i && cand_vld) begin
                        // A grant always wins over a timeout firing this cycle.
                        out_data_q <= slice_data[cand_id];
                        out_en_q   <= 1'b1;
                        ready_q    <= N'(1) << cand_id;
                        grant_id_q <= cand_id;
                        tmo_q      <= '0;
                        if (req_last_i[cand_id]) begin
                            locked_q <= 1'b0;
                            rr_q     <= rr_cand_d;
                        end else begin
                            locked_q <= 1'b1;
                        end
                        state_q <= ST_ISSUE;
                    end else if (tmo_fire) begin
                        locked_q <= 1'b0;
                        rr_q     <= rr_own_d;
                        tmo_q    <= '0;
                    end else if (!locked_q) begin
                        tmo_q <= '0;
                    end else if ((LOCK_TIMEOUT != 0) && !req_valid_i[grant_id_q]) begin
                        tmo_q <= tmo_q + CNTW'(1);
                    end
                end
                ST_ISSUE: begin
                    out_en_q <= 1'b0;
                    ready_q  <= '0;
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!output_busy_i) begin
                        state_q <= ST_ARB;
                    end
                end
                default: begin
                    state_q <= ST_ARB;
                end
            endcase
        end
    end

    assign req_ready_o   = ready_q;
    assign output_en_o   = out_en_q;
    assign output_data_o = out_data_q;
    assign grant_id_o    = grant_id_q;
    assign locked_o      = locked_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single byte transmitter (output_en / output_data / output_busy handshake) between N byte-stream requesters, e.g. a puzzle result streamer and a debug echo.
- Round-robin arbitration with packet lock: once a requester starts a packet, the requester keeps the transmitter until its byte flagged last.
- A lock timeout keeps a stalled requester from hanging the link.
- Sits between the puzzle/debug cores and the UART TX.

Parameters:
- N, 2, number of requesters (2..8).
- IDW, 1, width of grant index; must equal max(1, clog2(N)).
- LOCK_TIMEOUT, 1000, cycles a locked owner may hold the link with req_valid low before the lock is dropped; 0 disables the timeout.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  N  requester i has a byte on its data slice.
- req_data  input  8*N  byte for requester i in bits [8i+7:8i].
- req_last  input  N  byte from requester i ends its packet.
- req_ready  output  N  one-cycle pulse: byte from requester i consumed.
- output_busy  input  1  transmitter busy with previous byte.
- output_en  output  1  one-cycle pulse: send output_data.
- output_data  output  8  byte to transmit.
- grant_id  output  IDW  index of last/current granted requester.
- locked  output  1  packet lock held by grant_id.

Behaviour:
- Reset (async, immediate): output_en=0, output_data=0, req_ready=0, grant_id=0, locked=0, rr pointer=0, timeout counter=0, state=ARB. Reset mid-transfer aborts the transfer; no pulse is completed or repeated.
- All outputs are registered.
- Requester rules:
  - Hold req_valid, data and last stable until req_ready.
  - A requester may drop req_valid without a ready; that byte is then not sent.
- FSM states: ARB, ISSUE, SETTLE, DRAIN.
- ARB:
  - Wait until output_busy=0 and an eligible request exists.
  - If locked, only grant_id is eligible.
  - If not locked, the first requester with req_valid=1 searching from rr pointer upward, wrapping at N, is eligible.
  - On grant g, in one clock edge:
    - output_data <= slice g; output_en <= 1; req_ready[g] <= 1; grant_id <= g.
    - If req_last[g]=0: locked <= 1.
    - If req_last[g]=1: locked <= 0 and rr pointer <= (g+1) mod N.
    - Next state is ISSUE.
- ISSUE: lasts one cycle while output_en and req_ready are high. Next edge clears both; next state is SETTLE.
- SETTLE: one cycle with output_busy ignored, to cover the transmitter's busy-rise latency. Then DRAIN.
- DRAIN: wait for output_busy=0, then ARB.
- Grant spacing:
  - Minimum spacing between two output_en pulses is 4 cycles (ISSUE, SETTLE, DRAIN with 0 busy, ARB).
  - Exactly one output_en pulse per req_ready pulse, on the same cycle.
- Lock timeout:
  - Counter runs only in ARB while locked=1 and req_valid[grant_id]=0. It clears on any grant or when locked=0.
  - When the counter reaches LOCK_TIMEOUT, at the next edge locked <= 0 and rr pointer <= (grant_id+1) mod N. The counter clears.
  - Arbitration that cycle still uses the old lock.
- Simultaneous events:
  - Several requesters valid with no lock: the round-robin winner only; others see no ready.
  - Owner's valid rises in the same cycle the timeout fires: the owner is granted and the lock is kept (grant wins).
  - output_busy=1 in ARB: no grant, even if requests are pending; the timeout still counts.
- N=1: always grant 0; lock is still tracked.

Test Plan:
- Single byte: N=2, req0 sends 0x41 last=1, busy held 0 -> output_en pulse with output_data=0x41, req_ready=2'b01 on the same cycle, grant_id=0, locked=0, rr pointer=1.
- Round-robin: both requesters continuously valid, every byte last=1, data 0x30 / 0x61 -> output sequence 0x30,0x61,0x30,0x61, output_en pulses exactly 4 cycles apart with busy=0.
- Packet lock: req0 sends "ABC" (last only on C), req1 valid with 'x' throughout -> output A,B,C,x; locked=1 from A through B, 0 after C.
- Busy gating: busy asserted 2 cycles after each output_en for 10 cycles -> no output_en pulse while busy=1; next pulse follows busy falling by 1 cycle (DRAIN->ARB) plus the grant edge.
- Lock timeout: LOCK_TIMEOUT=5, req0 sends 'A' last=0 then drops valid, req1 valid with 'z' -> locked falls 5 ARB cycles later, then 'z' is sent, grant_id=1.
- Async reset mid-DRAIN with busy=1 -> all outputs zero immediately without a clock edge. After release with req1 valid, req1's byte is sent first (pointer=0, req0 idle), with no duplicate pulse.
